// File: rtl/pmem_arbiter.sv
// pmem_arbiter: shares the single physical-memory line port between the I-cache
// and the D-cache. One requester is granted at a time. Its request is latched
// into the pmem output registers and held until pmem_resp. The response is then
// steered back to the granted cache only.
//
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   i_mem_read/address          I-cache line read request (level-held until resp)
//   i_mem_rdata/resp            line data / completion pulse to I-cache
//   d_mem_read/write/address    D-cache line read / write-back request
//   d_mem_wdata                 D-cache write-back data
//   d_mem_rdata/resp            line data / completion pulse to D-cache
//   pmem_read/write/address     registered physical memory request
//   pmem_wdata                  registered physical memory write data
//   pmem_rdata/resp             physical memory read data / completion
//
// Optional feature: define PMEM_ARB_ROUND_ROBIN_EN to grant simultaneous I and D
// requests to the requester opposite the last grant. Left undefined, D always
// wins over I and the last-grant record has no effect.

module pmem_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned LINE_W = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_mem_read,
  input  logic [ADDR_W-1:0] i_mem_address,
  output logic [LINE_W-1:0] i_mem_rdata,
  output logic              i_mem_resp,
  input  logic              d_mem_read,
  input  logic              d_mem_write,
  input  logic [ADDR_W-1:0] d_mem_address,
  input  logic [LINE_W-1:0] d_mem_wdata,
  output logic [LINE_W-1:0] d_mem_rdata,
  output logic              d_mem_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StServeI = 2'd1;
  localparam logic [1:0] StServeD = 2'd2;

  localparam logic GrantI = 1'b0;
  localparam logic GrantD = 1'b1;

  logic [1:0]        state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic              pmem_read_q, pmem_read_d;
  logic              pmem_write_q, pmem_write_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LINE_W-1:0] wdata_q, wdata_d;

  logic d_req, i_req, pick_d;

  assign d_req = d_mem_read | d_mem_write;
  assign i_req = i_mem_read;

`ifdef PMEM_ARB_ROUND_ROBIN_EN
  // A lone D request always wins; on a tie D wins only if I had the last grant.
  assign pick_d = d_req & (~i_req | (last_grant_q == GrantI));
`else
  assign pick_d = d_req;
`endif

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    pmem_read_d  = pmem_read_q;
    pmem_write_d = pmem_write_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    case (state_q)
      StIdle: begin
        if (pick_d) begin
          state_d      = StServeD;
          last_grant_d = GrantD;
          // Read+write together is illegal; write takes precedence.
          pmem_write_d = d_mem_write;
          pmem_read_d  = ~d_mem_write;
          addr_d       = d_mem_address;
          wdata_d      = d_mem_wdata;
        end else if (i_req) begin
          state_d      = StServeI;
          last_grant_d = GrantI;
          pmem_read_d  = 1'b1;
          pmem_write_d = 1'b0;
          addr_d       = i_mem_address;
        end
      end
      StServeI, StServeD: begin
        // Requester inputs are ignored here; the latched copy drives pmem.
        if (pmem_resp) begin
          state_d      = StIdle;
          pmem_read_d  = 1'b0;
          pmem_write_d = 1'b0;
        end
      end
      default: begin
        state_d      = StIdle;
        pmem_read_d  = 1'b0;
        pmem_write_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      last_grant_q <= GrantI;
      pmem_read_q  <= 1'b0;
      pmem_write_q <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      pmem_read_q  <= pmem_read_d;
      pmem_write_q <= pmem_write_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
    end
  end

  assign pmem_read    = pmem_read_q;
  assign pmem_write   = pmem_write_q;
  assign pmem_address = addr_q;
  assign pmem_wdata   = wdata_q;

  // Completion is only forwarded to the cache that owns the current grant;
  // a pmem_resp seen in IDLE reaches nobody.
  assign i_mem_resp  = (state_q == StServeI) & pmem_resp;
  assign d_mem_resp  = (state_q == StServeD) & pmem_resp;
  assign i_mem_rdata = pmem_rdata;
  assign d_mem_rdata = pmem_rdata;

`ifndef SYNTHESIS
  d_rw_exclusive: assert property (@(posedge clk) disable iff (rst)
    (state_q == StIdle) |-> !(d_mem_read && d_mem_write))
    else $error("pmem_arbiter: d_mem_read and d_mem_write both high");

  strobe_exclusive: assert property (@(posedge clk) disable iff (rst)
    !(pmem_read_q && pmem_write_q))
    else $error("pmem_arbiter: pmem_read and pmem_write both high");

  idle_quiet: assert property (@(posedge clk) disable iff (rst)
    (state_q == StIdle) |-> !(pmem_read_q || pmem_write_q))
    else $error("pmem_arbiter: strobe high in IDLE");
`endif

endmodule

// File: tb/tb_pmem_arbiter.sv
// Scoreboard bench for pmem_arbiter: stimulus pushes the expected completion of
// each request into a queue; a monitor pops and compares on every cache resp.

module tb_pmem_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned LW = 256;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_mem_read;
  logic [AW-1:0] i_mem_address;
  logic [LW-1:0] i_mem_rdata;
  logic          i_mem_resp;
  logic          d_mem_read;
  logic          d_mem_write;
  logic [AW-1:0] d_mem_address;
  logic [LW-1:0] d_mem_wdata;
  logic [LW-1:0] d_mem_rdata;
  logic          d_mem_resp;
  logic          pmem_read;
  logic          pmem_write;
  logic [AW-1:0] pmem_address;
  logic [LW-1:0] pmem_wdata;
  logic [LW-1:0] pmem_rdata;
  logic          pmem_resp;

  // Memory model (auto) and manual response sources, merged onto pmem.
  logic          mem_en;
  logic          mem_resp;
  logic [LW-1:0] mem_rdata;
  logic          man_resp;
  logic [LW-1:0] man_rdata;
  int            mem_lat;

  assign pmem_resp  = mem_resp | man_resp;
  assign pmem_rdata = mem_resp ? mem_rdata : man_rdata;

  pmem_arbiter #(
    .ADDR_W(AW),
    .LINE_W(LW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .i_mem_read   (i_mem_read),
    .i_mem_address(i_mem_address),
    .i_mem_rdata  (i_mem_rdata),
    .i_mem_resp   (i_mem_resp),
    .d_mem_read   (d_mem_read),
    .d_mem_write  (d_mem_write),
    .d_mem_address(d_mem_address),
    .d_mem_wdata  (d_mem_wdata),
    .d_mem_rdata  (d_mem_rdata),
    .d_mem_resp   (d_mem_resp),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_address (pmem_address),
    .pmem_wdata   (pmem_wdata),
    .pmem_rdata   (pmem_rdata),
    .pmem_resp    (pmem_resp)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit            is_d;
    bit            wr;
    logic [AW-1:0] addr;
    logic [LW-1:0] wdata;
    logic [LW-1:0] rdata;
  } exp_t;

  exp_t sb[$];
  int   passed = 0;
  int   total  = 0;
  bit   tb_last_d;  // model of which requester was granted last

  function automatic void chk(input string name, input logic [LW-1:0] act,
                              input logic [LW-1:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h want %0h", name, act, exp);
  endfunction

  function automatic logic [LW-1:0] rdata_for(input logic [AW-1:0] a);
    return {8{a ^ 32'h5A5A_0F0F}};
  endfunction

  task automatic push(input bit is_d, input bit wr, input logic [AW-1:0] a,
                      input logic [LW-1:0] wd, input logic [LW-1:0] rd);
    exp_t e;
    e.is_d = is_d; e.wr = wr; e.addr = a; e.wdata = wd; e.rdata = rd;
    sb.push_back(e);
  endtask

  // Hold requests until their resp is seen, then drop them after that edge.
  task automatic run_until(input int budget, input bit want_i, input bit want_d);
    bit got_i = 1'b0;
    bit got_d = 1'b0;
    bit drop_i, drop_d;
    for (int c = 0; c < budget; c++) begin
      if ((got_i || !want_i) && (got_d || !want_d)) break;
      @(negedge clk);
      drop_i = i_mem_resp;
      drop_d = d_mem_resp;
      @(posedge clk); #1;
      if (drop_i) begin i_mem_read = 1'b0; got_i = 1'b1; end
      if (drop_d) begin d_mem_read = 1'b0; d_mem_write = 1'b0; got_d = 1'b1; end
    end
    chk("txn_timeout", 256'({got_i || !want_i, got_d || !want_d}), 256'd3);
  endtask

  // Simultaneous I and D read requests; grant order follows the model.
  task automatic sim_pair(input logic [AW-1:0] ia, input logic [AW-1:0] da);
    bit d_first;
`ifdef PMEM_ARB_ROUND_ROBIN_EN
    d_first = !tb_last_d;
`else
    d_first = 1'b1;
`endif
    if (d_first) begin
      push(1'b1, 1'b0, da, '0, rdata_for(da));
      push(1'b0, 1'b0, ia, '0, rdata_for(ia));
    end else begin
      push(1'b0, 1'b0, ia, '0, rdata_for(ia));
      push(1'b1, 1'b0, da, '0, rdata_for(da));
    end
    @(posedge clk); #1;
    i_mem_read = 1'b1; i_mem_address = ia;
    d_mem_read = 1'b1; d_mem_address = da;
    run_until(60, 1'b1, 1'b1);
    tb_last_d = !d_first;
  endtask

  // Auto memory: answers each strobe after mem_lat cycles with rdata_for(addr).
  initial begin
    int cnt = 0;
    mem_resp  = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      if (mem_resp) mem_resp = 1'b0;
      else if (mem_en && (pmem_read || pmem_write)) begin
        if (cnt == mem_lat) begin
          mem_resp  = 1'b1;
          mem_rdata = rdata_for(pmem_address);
          cnt = 0;
        end else cnt++;
      end else cnt = 0;
    end
  end

  // Monitor: compare each cache completion against the scoreboard head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && (i_mem_resp || d_mem_resp)) begin
        if (sb.size() == 0) begin
          chk("unexpected_resp", 256'({i_mem_resp, d_mem_resp}), 256'd0);
        end else begin
          e = sb.pop_front();
          chk("resp_port", 256'({i_mem_resp, d_mem_resp}), e.is_d ? 256'd1 : 256'd2);
          chk("resp_addr", 256'(pmem_address), 256'(e.addr));
          chk("resp_op", 256'({pmem_read, pmem_write}), e.wr ? 256'd1 : 256'd2);
          if (e.wr) chk("resp_wdata", pmem_wdata, e.wdata);
          else chk("resp_rdata", e.is_d ? d_mem_rdata : i_mem_rdata, e.rdata);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    i_mem_read = 1'b0; i_mem_address = '0;
    d_mem_read = 1'b0; d_mem_write = 1'b0; d_mem_address = '0; d_mem_wdata = '0;
    mem_en = 1'b0; man_resp = 1'b0; man_rdata = '0; mem_lat = 2;
    tb_last_d = 1'b0;
    repeat (2) @(posedge clk); #1;
    chk("rst_pmem_read", 256'(pmem_read), 256'd0);
    chk("rst_pmem_write", 256'(pmem_write), 256'd0);
    chk("rst_resps", 256'({i_mem_resp, d_mem_resp}), 256'd0);
    chk("rst_addr", 256'(pmem_address), 256'd0);
    chk("rst_wdata", pmem_wdata, 256'd0);
    rst = 1'b0;

    // Lone I read, manual memory returning A5 pattern.
    @(posedge clk); #1;
    push(1'b0, 1'b0, 32'h60, '0, {32{8'hA5}});
    i_mem_read = 1'b1; i_mem_address = 32'h60;
    @(negedge clk);
    chk("i_grant_cycle_no_strobe", 256'(pmem_read), 256'd0);
    @(posedge clk); #1;
    chk("i_strobe", 256'(pmem_read), 256'd1);
    chk("i_addr", 256'(pmem_address), 256'h60);
    repeat (3) @(posedge clk); #1;
    man_rdata = {32{8'hA5}}; man_resp = 1'b1;
    @(negedge clk);
    chk("i_resp_d_quiet", 256'({i_mem_resp, d_mem_resp}), 256'd2);
    @(posedge clk); #1;
    man_resp = 1'b0; i_mem_read = 1'b0;
    chk("i_strobe_drop", 256'(pmem_read), 256'd0);
    tb_last_d = 1'b0;

    // D write-back, auto memory.
    mem_en = 1'b1;
    @(posedge clk); #1;
    push(1'b1, 1'b1, 32'h1000, 256'h1234, '0);
    d_mem_write = 1'b1; d_mem_address = 32'h1000; d_mem_wdata = 256'h1234;
    @(posedge clk); #1;
    chk("dw_op", 256'({pmem_read, pmem_write}), 256'd1);
    chk("dw_wdata", pmem_wdata, 256'h1234);
    run_until(40, 1'b0, 1'b1);
    tb_last_d = 1'b1;

    // Simultaneous requests (order depends on build).
    sim_pair(32'h40, 32'h80);

    // Mid-transaction address change must not disturb pmem_address.
    @(posedge clk); #1;
    push(1'b1, 1'b0, 32'h80, '0, rdata_for(32'h80));
    d_mem_read = 1'b1; d_mem_address = 32'h80;
    @(posedge clk); #1;
    chk("mid_addr_before", 256'(pmem_address), 256'h80);
    d_mem_address = 32'hC0;
    @(posedge clk); #1;
    chk("mid_addr_after", 256'(pmem_address), 256'h80);
    run_until(40, 1'b0, 1'b1);
    tb_last_d = 1'b1;

    // Stray pmem_resp in IDLE.
    @(posedge clk); #1;
    man_rdata = '1; man_resp = 1'b1;
    @(negedge clk);
    chk("stray_no_resp", 256'({i_mem_resp, d_mem_resp}), 256'd0);
    @(posedge clk); #1;
    man_resp = 1'b0;
    chk("stray_no_strobe", 256'({pmem_read, pmem_write}), 256'd0);

    // Reset two cycles into SERVE_I.
    mem_en = 1'b0;
    @(posedge clk); #1;
    i_mem_read = 1'b1; i_mem_address = 32'h200;
    @(posedge clk); #1;
    chk("rst_mid_strobe", 256'(pmem_read), 256'd1);
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("rst_mid_async_drop", 256'(pmem_read), 256'd0);
    chk("rst_mid_addr", 256'(pmem_address), 256'd0);
    i_mem_read = 1'b0;
    @(negedge clk); rst = 1'b0;
    tb_last_d = 1'b0;
    @(posedge clk); #1;
    man_resp = 1'b1;
    @(posedge clk); #1;
    man_resp = 1'b0;
    chk("rst_late_resp_idle", 256'(pmem_read), 256'd0);

    // Next request after reset is granted normally.
    mem_en = 1'b1;
    @(posedge clk); #1;
    push(1'b0, 1'b0, 32'h300, '0, rdata_for(32'h300));
    i_mem_read = 1'b1; i_mem_address = 32'h300;
    @(posedge clk); #1;
    chk("post_rst_grant", 256'(pmem_read), 256'd1);
    run_until(40, 1'b1, 1'b0);
    tb_last_d = 1'b0;

    // Lone D then a tie: round robin must favour I here, fixed priority D.
    @(posedge clk); #1;
    push(1'b1, 1'b1, 32'h500, 256'hBEEF, '0);
    d_mem_write = 1'b1; d_mem_address = 32'h500; d_mem_wdata = 256'hBEEF;
    run_until(40, 1'b0, 1'b1);
    tb_last_d = 1'b1;
    sim_pair(32'h540, 32'h580);

    // Fresh reset, then three rounds of ties.
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk); #1;
    rst = 1'b0;
    tb_last_d = 1'b0;
    for (int k = 0; k < 3; k++) begin
      sim_pair(32'h2000 + 32'(k) * 32'h100, 32'h1000 + 32'(k) * 32'h100);
    end

    repeat (3) @(posedge clk); #1;
    chk("sb_drained", 256'(sb.size()), 256'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
